// File: rtl/fm_core_mux.sv
// rtl/fm_core_mux.sv - time-multiplexed FM operator engine producing one saturated mixed sample per frame
//
// Purpose:
//   Runs NUM_VOICES x NUM_OPERATORS operator slots per frame through a fixed
//   4-stage pipeline: S0 phase issue (+ optional inter-operator modulation),
//   S1 triangle waveform, S2 envelope gain with saturation, S3 carrier mix.
//   Slots are operator-major: slot s -> op = s / NUM_VOICES, voice = s % NUM_VOICES.
//
// Ports:
//   i_Clock        clock
//   i_Reset        synchronous active-high reset
//   i_CfgWe        config write strobe
//   i_CfgVoice     voice index of write
//   i_CfgOp        operator index of write (out-of-range writes are dropped)
//   i_CfgPhaseStep unsigned phase increment per frame
//   i_CfgEnvLevel  signed Q1.(W-1) envelope gain
//   i_CfgModEn     modulate by operator op-1 of the same voice
//   i_CfgCarrier   add operator output to the mix
//   o_Sample       signed saturated mixed sample, held between pulses
//   o_SampleValid  one-cycle pulse when o_Sample updates
//
// Optional feature macro: FM_CORE_FEEDBACK_EN
//   Defined: op 0 with ModEn=1 is modulated at half depth by its own output
//   from the previous frame (per-voice fb_out register).
//   Undefined: ModEn on op 0 has no effect and no feedback storage exists.

module fm_core_mux #(
  parameter int NUM_VOICES    = 16,
  parameter int NUM_OPERATORS = 6,
  parameter int PHASE_WIDTH   = 16,
  parameter int SAMPLE_WIDTH  = 16
) (
  input  logic                                                       i_Clock,
  input  logic                                                       i_Reset,
  input  logic                                                       i_CfgWe,
  input  logic [$clog2(NUM_VOICES)-1:0]                              i_CfgVoice,
  input  logic [((NUM_OPERATORS > 1) ? $clog2(NUM_OPERATORS) : 1)-1:0] i_CfgOp,
  input  logic [PHASE_WIDTH-1:0]                                     i_CfgPhaseStep,
  input  logic [SAMPLE_WIDTH-1:0]                                    i_CfgEnvLevel,
  input  logic                                                       i_CfgModEn,
  input  logic                                                       i_CfgCarrier,
  output logic [SAMPLE_WIDTH-1:0]                                    o_Sample,
  output logic                                                       o_SampleValid
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int OW = (NUM_OPERATORS > 1) ? $clog2(NUM_OPERATORS) : 1;
  localparam int N  = NUM_VOICES * NUM_OPERATORS;
  localparam int SW = (N > 1) ? $clog2(N) : 1;
  localparam int PW = PHASE_WIDTH;
  localparam int W  = SAMPLE_WIDTH;
  localparam int SH = PW - W;
  localparam int MW = W + $clog2(N);

  localparam logic [W-1:0]          HALF    = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0]          HALF_M1 = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PMAX    = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] PMIN    = {{(W+1){1'b1}}, {(W-1){1'b0}}};
  localparam logic signed [MW:0]    MMAX    = {{(MW-W+2){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [MW:0]    MMIN    = {{(MW-W+2){1'b1}}, {(W-1){1'b0}}};

  // ---------------------------------------------------------------------------
  // Slot sequencing: voice runs fastest, operator advances on voice wrap.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] slot;
  logic [VW-1:0] voice;
  logic [OW-1:0] op;
  logic          slot_last;
  logic          voice_last;
  logic          op_last;

  assign slot_last  = (slot == SW'(N - 1));
  assign voice_last = (voice == VW'(NUM_VOICES - 1));
  assign op_last    = (op == OW'(NUM_OPERATORS - 1));

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      slot  <= '0;
      voice <= '0;
      op    <= '0;
    end else begin
      slot <= slot_last ? '0 : slot + 1'b1;
      if (voice_last) begin
        voice <= '0;
        op    <= op_last ? '0 : op + 1'b1;
      end else begin
        voice <= voice + 1'b1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Per-slot config, stored at the slot index op*V + voice.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        cfg_step [N];
  logic signed [W-1:0]  cfg_env  [N];
  logic                 cfg_mod  [N];
  logic                 cfg_car  [N];
  logic                 cfg_hit;
  logic [SW-1:0]        cfg_idx;

  always_comb begin
    cfg_hit = i_CfgWe && (int'(i_CfgOp) < NUM_OPERATORS) && (int'(i_CfgVoice) < NUM_VOICES);
    cfg_idx = SW'(int'(i_CfgOp) * NUM_VOICES + int'(i_CfgVoice));
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < N; i++) begin
        cfg_step[i] <= '0;
        cfg_env[i]  <= '0;
        cfg_mod[i]  <= 1'b0;
        cfg_car[i]  <= 1'b0;
      end
    end else if (cfg_hit) begin
      cfg_step[cfg_idx] <= i_CfgPhaseStep;
      cfg_env[cfg_idx]  <= i_CfgEnvLevel;
      cfg_mod[cfg_idx]  <= i_CfgModEn;
      cfg_car[cfg_idx]  <= i_CfgCarrier;
    end
  end

  // ---------------------------------------------------------------------------
  // S0: phase issue. The accumulator value used is the pre-increment one.
  // ---------------------------------------------------------------------------
  logic [PW-1:0]        acc [N];
  logic signed [W-1:0]  prev_out [NUM_VOICES];
  logic signed [PW-1:0] prev_ext;
  logic [PW-1:0]        mod_term;
`ifdef FM_CORE_FEEDBACK_EN
  logic signed [W-1:0]  fb_out [NUM_VOICES];
  logic signed [PW-1:0] fb_ext;
`endif

  always_comb begin
    mod_term = '0;
    prev_ext = PW'(prev_out[voice]);
    if (cfg_mod[slot] && (op != '0)) begin
      mod_term = prev_ext << SH;
    end
`ifdef FM_CORE_FEEDBACK_EN
    fb_ext = PW'(fb_out[voice]);
    if (cfg_mod[slot] && (op == '0)) begin
      mod_term = $signed(fb_ext << SH) >>> 1;
    end
`endif
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      for (int i = 0; i < N; i++) begin
        acc[i] <= '0;
      end
    end else begin
      acc[slot] <= acc[slot] + cfg_step[slot];
    end
  end

  // ---------------------------------------------------------------------------
  // S1: triangle from the top W phase bits.
  // S2: envelope product, rescaled by W-1; only -1 x -1 can overflow.
  // ---------------------------------------------------------------------------
  logic                 p1_valid, p2_valid, p3_valid;
  logic [PW-1:0]        p1_phase;
  logic signed [W-1:0]  p1_env, p2_env;
  logic                 p1_car, p2_car, p3_car;
  logic [VW-1:0]        p1_voice, p2_voice, p3_voice;
  logic                 p1_last, p2_last, p3_last;
  logic signed [W-1:0]  p2_amp;
  logic signed [W-1:0]  p3_out;
`ifdef FM_CORE_FEEDBACK_EN
  logic                 p1_first, p2_first, p3_first;
`endif

  logic [W-1:0]         tri_u;
  logic [W-1:0]         tri_v;
  logic signed [W-1:0]  amp;
  logic signed [2*W-1:0] prod;
  logic signed [2*W-1:0] prod_sh;
  logic signed [W-1:0]  gain_out;

  always_comb begin
    tri_u = p1_phase[PW-1 -: W];
    tri_v = {tri_u[W-2:0], 1'b0};
    amp   = tri_u[W-1] ? $signed(HALF_M1 - tri_v) : $signed(tri_v - HALF);
  end

  always_comb begin
    prod    = (2*W)'(p2_amp) * (2*W)'(p2_env);
    prod_sh = prod >>> (W - 1);
    if (prod_sh > PMAX) begin
      gain_out = PMAX[W-1:0];
    end else if (prod_sh < PMIN) begin
      gain_out = PMIN[W-1:0];
    end else begin
      gain_out = prod_sh[W-1:0];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      p1_valid <= 1'b0;
      p2_valid <= 1'b0;
      p3_valid <= 1'b0;
      p1_phase <= '0;
      p1_env   <= '0;
      p2_env   <= '0;
      p1_car   <= 1'b0;
      p2_car   <= 1'b0;
      p3_car   <= 1'b0;
      p1_voice <= '0;
      p2_voice <= '0;
      p3_voice <= '0;
      p1_last  <= 1'b0;
      p2_last  <= 1'b0;
      p3_last  <= 1'b0;
      p2_amp   <= '0;
      p3_out   <= '0;
`ifdef FM_CORE_FEEDBACK_EN
      p1_first <= 1'b0;
      p2_first <= 1'b0;
      p3_first <= 1'b0;
`endif
    end else begin
      // Env and carrier are captured at issue so a later write cannot
      // split one slot's config across stages.
      p1_valid <= 1'b1;
      p1_phase <= acc[slot] + mod_term;
      p1_env   <= cfg_env[slot];
      p1_car   <= cfg_car[slot];
      p1_voice <= voice;
      p1_last  <= slot_last;

      p2_valid <= p1_valid;
      p2_amp   <= amp;
      p2_env   <= p1_env;
      p2_car   <= p1_car;
      p2_voice <= p1_voice;
      p2_last  <= p1_last;

      p3_valid <= p2_valid;
      p3_out   <= gain_out;
      p3_car   <= p2_car;
      p3_voice <= p2_voice;
      p3_last  <= p2_last;
`ifdef FM_CORE_FEEDBACK_EN
      p1_first <= (op == '0);
      p2_first <= p1_first;
      p3_first <= p2_first;
`endif
    end
  end

  // ---------------------------------------------------------------------------
  // S3: modulation source update and carrier mix.
  // ---------------------------------------------------------------------------
  logic signed [MW-1:0] mix_acc;
  logic signed [MW:0]   add_term;
  logic signed [MW:0]   mix_sum;
  logic signed [W-1:0]  mix_sat;

  always_comb begin
    add_term = '0;
    if (p3_car) begin
      add_term = (MW+1)'(p3_out);
    end
    mix_sum = (MW+1)'(mix_acc) + add_term;
    if (mix_sum > MMAX) begin
      mix_sat = MMAX[W-1:0];
    end else if (mix_sum < MMIN) begin
      mix_sat = MMIN[W-1:0];
    end else begin
      mix_sat = mix_sum[W-1:0];
    end
  end

  always_ff @(posedge i_Clock) begin
    if (i_Reset) begin
      mix_acc       <= '0;
      o_Sample      <= '0;
      o_SampleValid <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        prev_out[i] <= '0;
`ifdef FM_CORE_FEEDBACK_EN
        fb_out[i]   <= '0;
`endif
      end
    end else begin
      o_SampleValid <= p3_valid && p3_last;
      if (p3_valid) begin
        prev_out[p3_voice] <= p3_out;
`ifdef FM_CORE_FEEDBACK_EN
        if (p3_first) begin
          fb_out[p3_voice] <= p3_out;
        end
`endif
        // Last slot closes the frame; the next frame starts from zero
        // on the very next slot.
        if (p3_last) begin
          o_Sample <= mix_sat;
          mix_acc  <= '0;
        end else begin
          mix_acc  <= mix_sum[MW-1:0];
        end
      end
    end
  end

endmodule

// File: tb/tb_fm_core_mux.sv
// tb/tb_fm_core_mux.sv - self-checking bench for fm_core_mux against a frame-level behavioural model

module tb_fm_core_mux;

  localparam int V = 16;
  localparam int O = 6;
  localparam int N = V * O;

  logic        clk = 1'b0;
  logic        rst;
  logic        we;
  logic [3:0]  cv;
  logic [2:0]  cop;
  logic [15:0] cstep;
  logic [15:0] cenv;
  logic        cmod;
  logic        ccar;
  logic [15:0] sample;
  logic        svalid;

  always #5 clk = ~clk;

  fm_core_mux dut (
    .i_Clock        (clk),
    .i_Reset        (rst),
    .i_CfgWe        (we),
    .i_CfgVoice     (cv),
    .i_CfgOp        (cop),
    .i_CfgPhaseStep (cstep),
    .i_CfgEnvLevel  (cenv),
    .i_CfgModEn     (cmod),
    .i_CfgCarrier   (ccar),
    .o_Sample       (sample),
    .o_SampleValid  (svalid)
  );

  int checks = 0;
  int failures = 0;

  // Reference model state: one entry per (op, voice) slot.
  int     m_acc  [N];
  int     m_step [N];
  int     m_env  [N];
  bit     m_mod  [N];
  bit     m_car  [N];
  int     m_prev [V];
  int     m_fb   [V];
  longint m_mix;
  int     exp_t[$];
  int     exp_v[$];
  int     exp_sample;
  int     cyc;
  int     pulse_cyc[$];
  int     pulse_val[$];

  task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int clamp16(input longint x);
    if (x > 32767) return 32767;
    if (x < -32768) return -32768;
    return int'(x);
  endfunction

  // Triangle over one phase period: -32768 at phase 0, +32767 at half period.
  function automatic int tri_amp(input int ph);
    int v;
    v = (2 * ph) % 65536;
    if (ph >= 32768) return 32767 - v;
    return v - 32768;
  endfunction

  function automatic int op_out(input int a, input int env);
    longint p;
    p = longint'(a) * longint'(env);
    p = p >>> 15;
    return clamp16(p);
  endfunction

  function automatic int pv(input int i);
    if (i < pulse_val.size()) return pulse_val[i];
    return 32'h7fff_ffff;
  endfunction

  function automatic int pc(input int i);
    if (i < pulse_cyc.size()) return pulse_cyc[i];
    return -1;
  endfunction

  // Called at each active edge: issues one slot, then applies this cycle's write.
  task automatic model_edge();
    int s, op, vc, ph, o, idx;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        m_acc[i] = 0; m_step[i] = 0; m_env[i] = 0; m_mod[i] = 0; m_car[i] = 0;
      end
      for (int i = 0; i < V; i++) begin
        m_prev[i] = 0; m_fb[i] = 0;
      end
      m_mix = 0;
      exp_t.delete(); exp_v.delete();
      pulse_cyc.delete(); pulse_val.delete();
      exp_sample = 0;
      cyc = 0;
    end else begin
      s  = cyc % N;
      op = s / V;
      vc = s % V;
      ph = m_acc[s];
      if (m_mod[s] && op != 0) ph = (ph + m_prev[vc]) & 65535;
`ifdef FM_CORE_FEEDBACK_EN
      if (m_mod[s] && op == 0) ph = (ph + (m_fb[vc] >>> 1)) & 65535;
`endif
      m_acc[s] = (m_acc[s] + m_step[s]) & 65535;
      o = op_out(tri_amp(ph), m_env[s]);
      m_prev[vc] = o;
      if (op == 0) m_fb[vc] = o;
      if (m_car[s]) m_mix += o;
      if (s == N - 1) begin
        exp_t.push_back(cyc + 4);
        exp_v.push_back(clamp16(m_mix));
        m_mix = 0;
      end
      if (we && int'(cop) < O) begin
        idx = int'(cop) * V + int'(cv);
        m_step[idx] = int'(cstep);
        m_env[idx]  = int'($signed(cenv));
        m_mod[idx]  = cmod;
        m_car[idx]  = ccar;
      end
      cyc++;
    end
  endtask

  task automatic check_outputs();
    int ev;
    ev = 0;
    if (exp_t.size() > 0 && exp_t[0] == cyc) begin
      ev = 1;
      exp_sample = exp_v[0];
      void'(exp_t.pop_front());
      void'(exp_v.pop_front());
    end
    check("sample_valid", {31'b0, svalid}, ev);
    check("sample", $signed(sample), exp_sample);
    if (svalid === 1'b1) begin
      pulse_cyc.push_back(cyc);
      pulse_val.push_back(int'($signed(sample)));
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    we  = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  task automatic cfg_write(input int v, input int o, input int step, input int env, input bit mod, input bit car);
    we = 1'b1; cv = 4'(v); cop = 3'(o); cstep = 16'(step); cenv = 16'(env); cmod = mod; ccar = car;
    tick();
    we = 1'b0;
  endtask

  initial begin
    rst = 1'b1; we = 1'b0; cv = '0; cop = '0; cstep = '0; cenv = '0; cmod = 1'b0; ccar = 1'b0;

    // Defaults: silent output, pulse at 99 then every 96 cycles.
    do_reset(3);
    check("reset_sample", $signed(sample), 0);
    check("reset_valid", {31'b0, svalid}, 0);
    repeat (200) tick();
    check("default_pulse_count", pulse_cyc.size(), 2);
    check("default_first_pulse", pc(0), 99);
    check("default_period", pc(1) - pc(0), 96);

    // Single carrier at phase 0: amp -32768 gives -32767.
    do_reset(1);
    cfg_write(0, 0, 16'h0000, 16'h7FFF, 0, 1);
    repeat (400) tick();
    check("const_frame0", pv(0), 0);
    check("const_frame1", pv(1), -32767);
    check("const_frame3", pv(3), -32767);

    // Quarter-period step: -32767, 0, 32766, -1 cycle.
    do_reset(1);
    cfg_write(0, 0, 16'h4000, 16'h7FFF, 0, 1);
    repeat (490) tick();
    check("step_f1", pv(1), -32767);
    check("step_f2", pv(2), 0);
    check("step_f3", pv(3), 32766);
    check("step_f4", pv(4), -1);

    // Voice 2: op 1 phase-modulated by op 0 output.
    do_reset(1);
    cfg_write(2, 0, 0, 16'h7FFF, 0, 0);
    cfg_write(2, 1, 0, 16'h7FFF, 1, 1);
    repeat (200) tick();
    check("mod_f0", pv(0), 32764);
    check("mod_f1", pv(1), 32764);

    // Mix saturation, then the -1 x -1 product saturation in S2.
    do_reset(1);
    cfg_write(0, 0, 0, 16'h7FFF, 0, 1);
    cfg_write(1, 0, 0, 16'h7FFF, 0, 1);
    repeat (250) tick();
    check("mixsat_f1", pv(1), -32768);
    cfg_write(3, 5, 0, 16'h8000, 0, 1);
    repeat (200) tick();
    check("prodsat_f2", pv(2), -32767);
    check("prodsat_f3", pv(3), -32767);

    // Randomised config traffic, including out-of-range operator indices.
    do_reset(1);
    for (int i = 0; i < 1500; i++) begin
      we    = ($urandom_range(0, 3) == 0);
      cv    = 4'($urandom_range(0, 15));
      cop   = 3'($urandom_range(0, 7));
      cstep = 16'($urandom);
      cenv  = 16'($urandom);
      cmod  = 1'($urandom_range(0, 1));
      ccar  = 1'($urandom_range(0, 1));
      tick();
    end
    we = 1'b0;

    // Write during reset and write to op 7 are both dropped; mid-frame reset
    // abandons the frame and restarts pulse timing.
    rst = 1'b1; we = 1'b1; cv = 4'd0; cop = 3'd0; cstep = 16'h0; cenv = 16'h7FFF; cmod = 1'b0; ccar = 1'b1;
    tick();
    rst = 1'b0; we = 1'b0;
    cfg_write(0, 7, 0, 16'h7FFF, 0, 1);
    repeat (49) tick();
    check("pre_reset_cycle", cyc, 50);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    repeat (200) tick();
    check("post_reset_first_pulse", pc(0), 99);
    check("post_reset_period", pc(1) - pc(0), 96);
    check("ignored_write_sample", pv(1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
